booth_mult_seq: RTL and testbench



---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_recoder.sv | 24 ++
 rtl/booth_mult_seq.sv | 118 +++++++++++
 tb/tb_booth_mult_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: digit codes,
// FSM state encoding and the iteration-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'b000,
    DIG_P1   = 3'b001,
    DIG_P2   = 3'b010,
    DIG_M2   = 3'b110,
    DIG_M1   = 3'b111
  } digit_t;

  function automatic int booth_iters(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window
// {b[2i+1], b[2i], b[2i-1]} onto a signed digit code.
module booth_recoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output digit_t     digit
);

  always_comb begin
    digit = DIG_ZERO;
    unique case (window)
      3'b000: digit = DIG_ZERO;
      3'b001: digit = DIG_P1;
      3'b010: digit = DIG_P1;
      3'b011: digit = DIG_P2;
      3'b100: digit = DIG_M2;
      3'b101: digit = DIG_M1;
      3'b110: digit = DIG_M1;
      3'b111: digit = DIG_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock.
// Optional BOOTH_EARLY_TERM_EN stops once remaining digits are zero.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inValid,
  output logic               inReady,
  input  logic [WIDTH-1:0]   multA,
  input  logic [WIDTH-1:0]   multB,
  output logic               outValid,
  input  logic               outReady,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(booth_iters(WIDTH) - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W:0]   sh2;
  logic [WIDTH:0]   b_ext;
  logic [2:0]       window;
  digit_t           digit;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    pp_base;
  logic [PW-1:0]    pp;
  logic             last;

  assign sh2    = {cnt, 1'b0};
  assign b_ext  = {b_q, 1'b0};
  assign window = 3'(b_ext >> sh2);
  assign a_ext  = {{WIDTH{a_q[WIDTH-1]}}, a_q};

  booth_recoder u_rec (
    .window (window),
    .digit  (digit)
  );

  always_comb begin
    pp_base = '0;
    unique case (digit)
      DIG_ZERO: pp_base = '0;
      DIG_P1:   pp_base = a_ext;
      DIG_P2:   pp_base = a_ext << 1;
      DIG_M1:   pp_base = -a_ext;
      DIG_M2:   pp_base = -(a_ext << 1);
      default:  pp_base = '0;
    endcase
  end

  assign pp = pp_base << sh2;

`ifdef BOOTH_EARLY_TERM_EN
  // Bits above 2i all equal -> every later window is 000 or 111.
  logic [CNT_W:0]   sh_rest;
  logic [WIDTH-1:0] b_rest;
  assign sh_rest = {cnt, 1'b1};
  assign b_rest  = $signed(b_q) >>> sh_rest;
  assign last    = (cnt == LAST) || (b_rest == '0) || (&b_rest);
`else
  assign last = (cnt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inReady  <= 1'b1;
      outValid <= 1'b0;
      busy     <= 1'b0;
      product  <= '0;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inValid && inReady) begin
            a_q     <= multA;
            b_q     <= multB;
            product <= '0;
            cnt     <= '0;
            inReady <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          product <= product + pp;
          cnt     <= cnt + 1'b1;
          if (last) begin
            busy     <= 1'b0;
            outValid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (outReady) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: directed vectors, backpressure,
// ignored input during RUN, mid-run reset and a signed random sweep.
module tb_booth_mult_seq;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           inValid = 1'b0;
  logic           inReady;
  logic [W-1:0]   multA = '0;
  logic [W-1:0]   multB = '0;
  logic           outValid;
  logic           outReady = 1'b1;
  logic [2*W-1:0] product;
  logic           busy;

  int n_pass = 0;
  int n_total = 0;
  int accepted = 0;
  int handshakes = 0;
  logic [2*W-1:0] exp_q[$];
  logic rnd_done = 1'b0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(W), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .inReady  (inReady),
    .multA    (multA),
    .multB    (multB),
    .outValid (outValid),
    .outReady (outReady),
    .product  (product),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic checkb(input string name, input logic got,
                        input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor: compare on every output handshake
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got 0x%08h expected none",
                 product);
      end else begin
        check("product", product, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] exp);
    int t = 0;
    multA   = a;
    multB   = b;
    inValid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!inReady && t < 200);
    if (!inReady) begin
      timeout("accept");
      inValid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp);
    accepted++;
    #1 inValid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!outValid && n < 50);
    if (!outValid) timeout("outValid");
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) timeout("drain");
    #1;
  endtask

  initial begin
    int lat;
    int t;
    logic ok;
    logic [W-1:0]   ta[4];
    logic [W-1:0]   tb[4];
    logic [2*W-1:0] te[4];
    logic signed [W-1:0]   ra;
    logic signed [W-1:0]   rb;
    logic signed [2*W-1:0] re;

    ta = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    tb = '{16'h8000, 16'hFFFF, 16'h1234, 16'hFFFF};
    te = '{32'h40000000, 32'hFFFF8001, 32'h00000000, 32'h00000001};

    repeat (2) @(posedge clk);
    #1;
    checkb("rst_inReady", inReady, 1'b1);
    checkb("rst_outValid", outValid, 1'b0);
    checkb("rst_busy", busy, 1'b0);
    check("rst_product", product, 32'h0);
    rst = 1'b0;

    // basic 3*5 with latency
    send(16'd3, 16'd5, 32'h0000000F);
    wait_out(lat);
`ifdef BOOTH_EARLY_TERM_EN
    checkb("latency", (lat >= 1 && lat <= 8), 1'b1);
`else
    check("latency", lat, 32'd8);
`endif
    checkb("t1_inReady_done", inReady, 1'b0);
    @(posedge clk);
    #1;
    checkb("t1_inReady_after", inReady, 1'b1);
    checkb("t1_outValid_drop", outValid, 1'b0);

    for (int i = 0; i < 4; i++) send(ta[i], tb[i], te[i]);
    drain();

    // backpressure
    outReady = 1'b0;
    send(16'h1234, 16'h0010, 32'h00012340);
    wait_out(lat);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!outValid || product !== 32'h00012340 || inReady || busy)
        ok = 1'b0;
    end
    checkb("bp_hold", ok, 1'b1);
    @(posedge clk);
    #1 outReady = 1'b1;
    @(posedge clk);
    #1;
    checkb("bp_release_inReady", inReady, 1'b1);
    checkb("bp_release_outValid", outValid, 1'b0);

    // inValid held with other operands during RUN
    send(16'd100, 16'hFFFD, 32'hFFFFFED4);
    multA   = 16'd5;
    multB   = 16'd7;
    inValid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!outValid && t < 50);
    inValid = 1'b0;
    if (!outValid) timeout("t4_outValid");
    @(posedge clk);
    #1;
    checkb("t4_inReady", inReady, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkb("t4_no_extra", outValid, 1'b0);

    // reset at counter=3
    send(16'h1111, 16'h5555, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkb("t5_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    accepted--;
    checkb("t5_inReady", inReady, 1'b1);
    checkb("t5_outValid", outValid, 1'b0);
    checkb("t5_busy", busy, 1'b0);
    check("t5_product", product, 32'h0);
    send(16'hFFF9, 16'd9, 32'hFFFFFFC1);
    drain();

    // random back-to-back with stalls
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ra = W'($urandom);
          rb = W'($urandom);
          re = ra * rb;
          send(ra, rb, re);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 outReady = ($urandom_range(0, 3) != 0);
        end
        outReady = 1'b1;
      end
    join
    drain();
    repeat (2) @(posedge clk);
    check("handshake_count", handshakes, accepted);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
